// File: rtl/vga_timing_out.sv
// vga_timing_out
//   Pixel-clock VGA timing generator and DAC output stage. Free-running
//   horizontal/vertical counters feed the object drawers through pixelX and
//   pixelY. Raw sync and active flags are delayed by PIPE_DELAY clocks so
//   that they line up with the colour coming back from the drawer/mux
//   pipeline. A final register stage then drives colour and sync to the
//   pins together. Colour is forced to black whenever the delayed active
//   flag is low.
//
// Ports
//   clk, resetN          pixel clock, asynchronous active-low reset
//   redIn/greenIn/blueIn colour returned by the object mux, PIPE_DELAY clocks
//                        after the matching pixelX/pixelY
//   pixelX, pixelY       current counters (direct register outputs)
//   visible              pixelX/pixelY lie inside the active area
//   startOfFrame         one-clock pulse at (0, V_ACTIVE)
//   vgaR/vgaG/vgaB       DAC colour
//   vgaHS, vgaVS         syncs, asserted level SYNC_ACTIVE
//   vgaBlankN            high while the DAC shows an active pixel
`timescale 1ns/1ps

module vga_timing_out #(
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIPE_DELAY  = 2      // legal range 1..8
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        visible,
    output logic        startOfFrame,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
    } timing_t;

    logic [10:0] h_cnt, v_cnt;
    logic [10:0] h_nxt, v_nxt;
    logic        h_wrap;
    logic        sof;
    timing_t     raw;
    timing_t     dly;
    timing_t [PIPE_DELAY-1:0] dly_pipe;

    // ---------------- counters ----------------
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? 11'd0 : h_cnt + 11'd1;
        v_nxt  = v_cnt;
        if (h_wrap)
            v_nxt = (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
    end

    // startOfFrame is decoded from the next counter values so the registered
    // pulse sits in the same cycle as pixelX==0 && pixelY==V_ACTIVE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
            sof   <= 1'b0;
        end else begin
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
            sof   <= (h_nxt == 11'd0) && (v_nxt == V_ACT);
        end
    end

    assign pixelX       = h_cnt;
    assign pixelY       = v_cnt;
    assign startOfFrame = sof;
    assign visible      = (h_cnt < H_ACT) && (v_cnt < V_ACT);

    // ---------------- raw timing ----------------
    always_comb begin
        raw.hs  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        raw.vs  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
        raw.act = visible;
    end

    // ---------------- delay line ----------------
    // Matches the drawer+mux latency. Reset flushes every stage to inactive
    // so a mid-frame reset cannot leak a partial sync or stale colour.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dly_pipe <= '0;
        end else begin
            dly_pipe[0] <= raw;
            for (int i = 1; i < PIPE_DELAY; i++)
                dly_pipe[i] <= dly_pipe[i-1];
        end
    end

    assign dly = dly_pipe[PIPE_DELAY-1];

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            vgaR      <= '0;
            vgaG      <= '0;
            vgaB      <= '0;
            vgaHS     <= ~SYNC_ACTIVE;
            vgaVS     <= ~SYNC_ACTIVE;
            vgaBlankN <= 1'b0;
        end else begin
            vgaR      <= dly.act ? redIn   : 8'd0;
            vgaG      <= dly.act ? greenIn : 8'd0;
            vgaB      <= dly.act ? blueIn  : 8'd0;
            vgaHS     <= dly.hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vgaVS     <= dly.vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vgaBlankN <= dly.act;
        end
    end

endmodule

// File: tb/tb_vga_timing_out.sv
`timescale 1ns/1ps

module tb_vga_timing_out;

    logic clk;
    logic rst_a, rst_b;
    int   checks = 0;
    int   fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: default 640x480 timing, PIPE_DELAY=2 ----------------
    logic [7:0]  red_a, green_a, blue_a;
    logic [10:0] pix_x_a, pix_y_a;
    logic        vis_a, sof_a, hs_a, vs_a, blank_n_a;
    logic [7:0]  r_a, g_a, b_a;
    logic        ff_a = 1'b0;

    vga_timing_out dut_a (
        .clk(clk), .resetN(rst_a),
        .redIn(red_a), .greenIn(green_a), .blueIn(blue_a),
        .pixelX(pix_x_a), .pixelY(pix_y_a), .visible(vis_a), .startOfFrame(sof_a),
        .vgaR(r_a), .vgaG(g_a), .vgaB(b_a),
        .vgaHS(hs_a), .vgaVS(vs_a), .vgaBlankN(blank_n_a)
    );

    // Drawer model, two clocks of latency.
    logic [10:0] ax1, ax2, ay1, ay2;
    always @(posedge clk) begin
        ax1 <= pix_x_a; ax2 <= ax1;
        ay1 <= pix_y_a; ay2 <= ay1;
    end
    assign red_a   = ff_a ? 8'hFF : ax2[7:0];
    assign green_a = ff_a ? 8'hFF : ay2[7:0];
    assign blue_a  = ff_a ? 8'hFF : 8'hA5;

    // ---------------- DUT B: tiny timing, PIPE_DELAY=1 ----------------
    logic [7:0]  red_b, green_b, blue_b;
    logic [10:0] pix_x_b, pix_y_b;
    logic        vis_b, sof_b, hs_b, vs_b, blank_n_b;
    logic [7:0]  r_b, g_b, b_b;

    vga_timing_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE(1'b0), .PIPE_DELAY(1)
    ) dut_b (
        .clk(clk), .resetN(rst_b),
        .redIn(red_b), .greenIn(green_b), .blueIn(blue_b),
        .pixelX(pix_x_b), .pixelY(pix_y_b), .visible(vis_b), .startOfFrame(sof_b),
        .vgaR(r_b), .vgaG(g_b), .vgaB(b_b),
        .vgaHS(hs_b), .vgaVS(vs_b), .vgaBlankN(blank_n_b)
    );

    logic [10:0] bx1, by1;
    always @(posedge clk) begin
        bx1 <= pix_x_b;
        by1 <= pix_y_b;
    end
    assign red_b   = bx1[7:0];
    assign green_b = by1[7:0];
    assign blue_b  = 8'hA5;

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic       act;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    function automatic exp_t mk(input int x, input int y, input int ha, input int hf,
                                input int hw, input int va, input int vf, input int vw);
        exp_t e;
        e.act = (x < ha) && (y < va);
        e.hs  = (x >= ha + hf) && (x < ha + hf + hw);
        e.vs  = (y >= va + vf) && (y < va + vf + vw);
        e.r   = e.act ? 8'(x) : 8'd0;
        e.g   = e.act ? 8'(y) : 8'd0;
        e.b   = e.act ? 8'hA5 : 8'd0;
        return e;
    endfunction

    // Expected DAC output pushed for each presented pixel, popped PIPE_DELAY+1
    // samples later. While in reset the queue is primed as if the release
    // cycle presented (0,0) with PIPE_DELAY inactive outputs ahead of it.
    exp_t qa[$];
    exp_t qb[$];
    int   mxa, mya, mxb, myb;
    exp_t ea, eb;

    always @(negedge clk) begin
        if (!rst_a) begin
            qa.delete();
            qa.push_back('0); qa.push_back('0);
            qa.push_back(mk(0, 0, 640, 16, 96, 480, 10, 2));
            mxa = 1; mya = 0;
        end else begin
            checks++;
            if ({pix_x_a, pix_y_a, vis_a, sof_a} !==
                {11'(mxa), 11'(mya), (mxa < 640) && (mya < 480), (mxa == 0) && (mya == 480)}) begin
                fails++;
                $display("FAIL cnt_a: got x=%0d y=%0d vis=%b sof=%b want x=%0d y=%0d",
                         pix_x_a, pix_y_a, vis_a, sof_a, mxa, mya);
            end
            qa.push_back(mk(mxa, mya, 640, 16, 96, 480, 10, 2));
            if (qa.size() > 3) begin
                ea = qa.pop_front();
                checks++;
                if ({blank_n_a, ~hs_a, ~vs_a, r_a, g_a, b_a} !== ea) begin
                    fails++;
                    $display("FAIL dac_a: got %h want %h (x=%0d y=%0d)",
                             {blank_n_a, ~hs_a, ~vs_a, r_a, g_a, b_a}, ea, mxa, mya);
                end
            end
            mxa++;
            if (mxa == 800) begin mxa = 0; mya++; if (mya == 525) mya = 0; end
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            qb.delete();
            qb.push_back('0);
            qb.push_back(mk(0, 0, 16, 2, 3, 4, 1, 1));
            mxb = 1; myb = 0;
        end else begin
            checks++;
            if ({pix_x_b, pix_y_b, vis_b, sof_b} !==
                {11'(mxb), 11'(myb), (mxb < 16) && (myb < 4), (mxb == 0) && (myb == 4)}) begin
                fails++;
                $display("FAIL cnt_b: got x=%0d y=%0d vis=%b sof=%b want x=%0d y=%0d",
                         pix_x_b, pix_y_b, vis_b, sof_b, mxb, myb);
            end
            qb.push_back(mk(mxb, myb, 16, 2, 3, 4, 1, 1));
            if (qb.size() > 2) begin
                eb = qb.pop_front();
                checks++;
                if ({blank_n_b, ~hs_b, ~vs_b, r_b, g_b, b_b} !== eb) begin
                    fails++;
                    $display("FAIL dac_b: got %h want %h", {blank_n_b, ~hs_b, ~vs_b, r_b, g_b, b_b}, eb);
                end
            end
            mxb++;
            if (mxb == 24) begin mxb = 0; myb++; if (myb == 7) myb = 0; end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_x_a(input int x, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (pix_x_a == 11'(x)) begin ok = 1'b1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        #1 rst_a = 1'b0; rst_b = 1'b0;
        #2;
        checks++;
        if ({pix_x_a, pix_y_a, vis_a, sof_a} !== {11'd0, 11'd0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_cnt: got x=%0d y=%0d vis=%b sof=%b want 0 0 1 0", pix_x_a, pix_y_a, vis_a, sof_a);
        end
        checks++;
        if ({r_a, g_a, b_a, blank_n_a, hs_a, vs_a} !== {24'd0, 1'b0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL reset_out: got rgb=%h bn=%b hs=%b vs=%b want 0 0 1 1", {r_a, g_a, b_a}, blank_n_a, hs_a, vs_a);
        end
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (pix_x_a !== 11'(k) || blank_n_a !== (k >= 3)) begin
                fails++;
                $display("FAIL release_seq: k=%0d got x=%0d bn=%b want x=%0d bn=%b", k, pix_x_a, blank_n_a, k, k >= 3);
            end
        end
    endtask

    task automatic test_variant;
        int k, pulses, first, hs_low, vs_low;
        @(negedge clk);
        #2 rst_b = 1'b1;
        @(negedge clk);
        checks++;
        if (blank_n_b !== 1'b0) begin fails++; $display("FAIL var_lat1: got bn=%b want 0", blank_n_b); end
        @(negedge clk);
        checks++;
        if ({blank_n_b, r_b, g_b, b_b} !== {1'b1, 8'd0, 8'd0, 8'hA5}) begin
            fails++; $display("FAIL var_lat2: got bn=%b rgb=%h want 1 0000a5", blank_n_b, {r_b, g_b, b_b});
        end
        @(negedge clk);
        checks++;
        if (r_b !== 8'd1) begin fails++; $display("FAIL var_lat3: got r=%0d want 1", r_b); end
        k = 0;
        while (sof_b !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        checks++;
        if (sof_b !== 1'b1 || pix_x_b !== 11'd0 || pix_y_b !== 11'd4) begin
            fails++; $display("FAIL var_sof_pos: got sof=%b x=%0d y=%0d want 1 0 4", sof_b, pix_x_b, pix_y_b);
        end
        pulses = 0; first = 0; hs_low = 0; vs_low = 0;
        for (int j = 1; j <= 336; j++) begin
            @(negedge clk);
            if (sof_b) begin pulses++; if (first == 0) first = j; end
            if (!hs_b) hs_low++;
            if (!vs_b) vs_low++;
        end
        checks++;
        if (pulses !== 2 || first !== 168) begin
            fails++; $display("FAIL var_sof_period: got pulses=%0d first=%0d want 2 168", pulses, first);
        end
        checks++;
        if (hs_low !== 42) begin fails++; $display("FAIL var_hs_width: got %0d want 42", hs_low); end
        checks++;
        if (vs_low !== 48) begin fails++; $display("FAIL var_vs_width: got %0d want 48", vs_low); end
    endtask

    task automatic test_line_timing;
        bit ok;
        logic [10:0] y0;
        int k, w;
        wait_x_a(799, ok);
        y0 = pix_y_a;
        @(negedge clk);
        checks++;
        if (!ok || pix_x_a !== 11'd0 || pix_y_a !== y0 + 11'd1) begin
            fails++; $display("FAIL line_wrap: got x=%0d y=%0d want 0 %0d", pix_x_a, pix_y_a, y0 + 11'd1);
        end
        k = 0;
        while (hs_a !== 1'b0 && k < 1000) begin @(negedge clk); k++; end
        checks++;
        if (k !== 659) begin fails++; $display("FAIL hs_start: got %0d want 659", k); end
        w = 0;
        while (hs_a === 1'b0 && w < 1000) begin @(negedge clk); w++; end
        checks++;
        if (w !== 96) begin fails++; $display("FAIL hs_width: got %0d want 96", w); end
        k = w;
        while (hs_a !== 1'b0 && k < 2000) begin @(negedge clk); k++; end
        checks++;
        if (k !== 800) begin fails++; $display("FAIL hs_period: got %0d want 800", k); end
    endtask

    task automatic test_colour_blank;
        bit ok;
        int bad;
        wait_x_a(650, ok);
        ff_a = 1'b1;
        bad = 0;
        for (int j = 0; j < 140; j++) begin
            @(negedge clk);
            if ({r_a, g_a, b_a} !== 24'd0) bad++;
        end
        ff_a = 1'b0;
        checks++;
        if (!ok || bad !== 0) begin
            fails++; $display("FAIL blank_black: got %0d nonzero samples (sync=%b) want 0", bad, ok);
        end
        repeat (900) @(negedge clk);
    endtask

    task automatic test_mid_reset;
        bit ok;
        int low;
        wait_x_a(700, ok);
        checks++;
        if (!ok || hs_a !== 1'b0) begin fails++; $display("FAIL pre_reset_hs: got %b want 0", hs_a); end
        #2 rst_a = 1'b0;
        #1;
        checks++;
        if ({hs_a, vs_a, blank_n_a, pix_x_a, pix_y_a} !== {1'b1, 1'b1, 1'b0, 11'd0, 11'd0}) begin
            fails++; $display("FAIL async_reset: got hs=%b vs=%b bn=%b x=%0d y=%0d want 1 1 0 0 0",
                              hs_a, vs_a, blank_n_a, pix_x_a, pix_y_a);
        end
        repeat (2) @(negedge clk);
        #2 rst_a = 1'b1;
        low = 0;
        for (int j = 1; j <= 658; j++) begin
            @(negedge clk);
            if (!hs_a) low++;
        end
        checks++;
        if (low !== 0) begin fails++; $display("FAIL no_stale_hs: got %0d low samples want 0", low); end
        @(negedge clk);
        checks++;
        if (hs_a !== 1'b0) begin fails++; $display("FAIL hs_after_reset: got %b want 0", hs_a); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_variant();
        test_line_timing();
        test_colour_blank();
        test_mid_reset();
        repeat (900) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Pixel-clock-domain VGA timing generator and output stage.
- Drives pixelX/pixelY to every object drawer, receives the final 24-bit colour back from the object priority mux, and drives the VGA DAC pins.
- Delays hsync/vsync/blank to cover the drawer+mux pipeline latency, so colour and sync leave the chip cycle-aligned.
- Forces black outside the active area.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 1'b0, asserted level of vgaHS/vgaVS
- PIPE_DELAY, 2, clocks from pixelX/pixelY output to matching colour on redIn/greenIn/blueIn; legal range 1..8

Ports:
- clk  in  1  pixel clock (25.175 MHz nominal)
- resetN  in  1  async active-low reset
- redIn  in  8  colour from object mux
- greenIn  in  8  colour from object mux
- blueIn  in  8  colour from object mux
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- visible  out  1  pixelX<H_ACTIVE && pixelY<V_ACTIVE, aligned with pixelX/pixelY
- startOfFrame  out  1  one-clock pulse at start of vertical blank
- vgaR  out  8  DAC red
- vgaG  out  8  DAC green
- vgaB  out  8  DAC blue
- vgaHS  out  1  horizontal sync
- vgaVS  out  1  vertical sync
- vgaBlankN  out  1  high while DAC shows an active pixel

Behaviour:
- Clock and reset: reset resetN, asynchronous, active-low; clock clk. All state is in clk domain.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counters:
  - hCnt increments every clk; wraps H_TOTAL-1 -> 0.
  - vCnt increments only on the hCnt wrap; wraps V_TOTAL-1 -> 0 on the same edge where hCnt wraps.
  - pixelX = hCnt, pixelY = vCnt, both direct register outputs.
- Raw timing, combinational from the counters:
  - hsRaw = hCnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vsRaw = vCnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
  - actRaw = visible
- Delay line: hsRaw/vsRaw/actRaw pass through a PIPE_DELAY-stage shift register. Reset value of every stage: inactive (hs=0, vs=0, act=0).
- Output register, one extra clock:
  - vgaR/G/B <= actDly ? colourIn : 0
  - vgaHS <= hsDly ? SYNC_ACTIVE : ~SYNC_ACTIVE (vgaVS likewise)
  - vgaBlankN <= actDly
- Latency: pixel (X,Y) presented at cycle t appears on vgaR/G/B, vgaBlankN and syncs at cycle t+PIPE_DELAY+1. Colour and sync always move together.
- startOfFrame: registered pulse, high for exactly one clock while pixelX==0 && pixelY==V_ACTIVE. Exactly once per V_TOTAL*H_TOTAL clocks.
- Reset values:
  - hCnt = vCnt = 0
  - visible = 1 (combinational from 0,0)
  - startOfFrame = 0
  - vgaR/G/B = 0, vgaBlankN = 0
  - vgaHS = vgaVS = ~SYNC_ACTIVE
- Reset mid-frame: counters restart at (0,0) immediately. The delay line flushes to inactive, so no partial sync pulse or stray colour is emitted from stale pipeline contents. The first valid colour appears PIPE_DELAY+1 clocks after reset release.
- Colour inputs are ignored (output 0) whenever the delayed active flag is low, including porches and sync regions, regardless of value.
- No back-pressure or handshake: timing is free-running and never stalls.

Test Plan:
- Reset release, PIPE_DELAY=2:
  - pixelX advances 0,1,2… from first edge; vgaBlankN stays 0 for 3 clocks, then 1.
  - vgaHS=vgaVS=1 throughout the first line's active region.
- Line timing:
  - vgaHS low for exactly 96 clocks per line, starting 656+3 clocks after each pixelX=0.
  - 800 clocks between successive falling edges.
  - pixelY increments exactly when pixelX wraps 799 -> 0.
- Frame timing:
  - vgaVS low for exactly 2 lines (1600 clocks), starting at line 490 (+3 clock offset).
  - startOfFrame pulses once every 420000 clocks, when pixelX=0, pixelY=480.
- Colour alignment:
  - Model a PIPE_DELAY=2 drawer returning redIn=pixelX[7:0], greenIn=pixelY[7:0], blueIn=8'hA5.
  - Every clock where vgaBlankN=1, vgaR/vgaG equal the X/Y presented 3 clocks earlier.
  - During blank, vgaR=vgaG=vgaB=0 even with inputs held at 8'hFF.
- Mid-frame reset:
  - Assert resetN=0 at pixelX=700, pixelY=200 (inside hsync).
  - vgaHS returns to 1 asynchronously; counters read (0,0) after release.
  - No vgaHS low pulse for the next 659 clocks.
- Parameter variant: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, PIPE_DELAY=1.
  - Line = 24 clocks, frame = 168 clocks.
  - hsync at hCnt 18..20; pixel-to-DAC latency of 2 clocks.
